char_buf_writer: RTL and testbench

- Writer side of the LCD character buffer: accepts a byte stream (ASCII plus control codes) on a valid/ready interface and writes glyph codes into the 2k x 8 character RAM that the LCD driver reads.
- Maintains the cursor and handles wrap-around, CR/LF/backspace and clear-screen.
- Sits between the host-facing source (UART/test logic) and the character RAM write port.

---
 rtl/charbuf_pkg.sv | 20 ++
 rtl/charbuf_cursor.sv | 57 +++++
 rtl/char_buf_writer.sv | 160 ++++++++++++++++
 tb/tb_char_buf_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/charbuf_pkg.sv
// Shared constants and types for the LCD character buffer writer.
package charbuf_pkg;

    localparam logic [7:0] CHR_BS        = 8'h08;
    localparam logic [7:0] CHR_LF        = 8'h0A;
    localparam logic [7:0] CHR_FF        = 8'h0C;
    localparam logic [7:0] CHR_CR        = 8'h0D;
    localparam logic [7:0] CHR_PRINT_MIN = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cb_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/charbuf_cursor.sv
// Row/column cursor for the character buffer; produces the linear cell offset row*COLS+col.
module charbuf_cursor
    import charbuf_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int ROWS   = 2,
    parameter int ADDR_W = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        adv,
    input  logic                        lf,
    input  logic                        cr,
    input  logic                        bs,
    input  logic                        home,
    output logic [cb_width(ROWS)-1:0]   row,
    output logic [cb_width(COLS)-1:0]   col,
    output logic [ADDR_W-1:0]           offset
);

    localparam int ROW_W = cb_width(ROWS);
    localparam int COL_W = cb_width(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    logic [ROW_W-1:0] row_inc;

    // No scrolling: the bottom row wraps straight back to the top.
    assign row_inc = (row == ROW_LAST) ? '0 : row + ROW_ONE;
    assign offset  = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row_inc;
            end else begin
                col <= col + COL_ONE;
            end
        end else if (lf) begin
            row <= row_inc;
        end else if (cr) begin
            col <= '0;
        end else if (bs && (col != '0)) begin
            col <= col - COL_ONE;
        end
    end

endmodule

// File: rtl/char_buf_writer.sv
// Writer side of the LCD character RAM: decodes a byte stream into glyph writes and clears.
// Define CHARBUF_CLR_ON_RST_EN to run a full-screen clear automatically out of reset.
module char_buf_writer
    import charbuf_pkg::*;
#(
    parameter int                COLS      = 16,
    parameter int                ROWS      = 2,
    parameter int                ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        FILL_CHAR = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    input  logic [7:0]                s_data,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [7:0]                wr_data,
    output logic [cb_width(ROWS)-1:0] cursor_row,
    output logic [cb_width(COLS)-1:0] cursor_col,
    output logic                      busy,
    output logic                      clr_done
);

    localparam int                CELLS    = ROWS * COLS;
    localparam int                IDX_W    = cb_width(CELLS);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef CHARBUF_CLR_ON_RST_EN
    localparam state_t STATE_RST = CLEAR;
    localparam logic   PRIME_RST = 1'b1;
`else
    localparam state_t STATE_RST = IDLE;
    localparam logic   PRIME_RST = 1'b0;
`endif

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic              prime, prime_nx;
    logic              wr_en_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [7:0]        wr_data_nx;
    logic              clr_done_nx;
    logic              cur_adv, cur_lf, cur_cr, cur_bs, cur_home;
    logic [ADDR_W-1:0] cur_offset;
    logic              accept;

    assign s_ready = (state == IDLE);
    assign busy    = (state == CLEAR);
    assign accept  = s_valid && s_ready;

    charbuf_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (cur_adv),
        .lf     (cur_lf),
        .cr     (cur_cr),
        .bs     (cur_bs),
        .home   (cur_home),
        .row    (cursor_row),
        .col    (cursor_col),
        .offset (cur_offset)
    );

    // The write outputs always hold the cell for the current idx while in CLEAR,
    // so each transition preloads the next cell. prime covers entry from reset,
    // where nothing has been preloaded yet.
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        prime_nx    = prime;
        wr_en_nx    = 1'b0;
        wr_addr_nx  = wr_addr;
        wr_data_nx  = wr_data;
        clr_done_nx = 1'b0;
        cur_adv     = 1'b0;
        cur_lf      = 1'b0;
        cur_cr      = 1'b0;
        cur_bs      = 1'b0;
        cur_home    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_data >= CHR_PRINT_MIN) begin
                        cur_adv    = 1'b1;
                        wr_en_nx   = 1'b1;
                        wr_addr_nx = BASE_ADDR + cur_offset;
                        wr_data_nx = s_data;
                    end else begin
                        case (s_data)
                            CHR_CR: cur_cr = 1'b1;
                            CHR_LF: cur_lf = 1'b1;
                            CHR_BS: begin
                                if (cursor_col != '0) begin
                                    cur_bs     = 1'b1;
                                    wr_en_nx   = 1'b1;
                                    wr_addr_nx = BASE_ADDR + cur_offset - ADDR_ONE;
                                    wr_data_nx = FILL_CHAR;
                                end
                            end
                            CHR_FF: begin
                                state_nx   = CLEAR;
                                idx_nx     = '0;
                                wr_en_nx   = 1'b1;
                                wr_addr_nx = BASE_ADDR;
                                wr_data_nx = FILL_CHAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                if (prime) begin
                    prime_nx   = 1'b0;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = BASE_ADDR + ADDR_W'(idx);
                    wr_data_nx = FILL_CHAR;
                end else if (idx == IDX_LAST) begin
                    state_nx    = IDLE;
                    cur_home    = 1'b1;
                    clr_done_nx = 1'b1;
                end else begin
                    idx_nx     = idx + IDX_ONE;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = BASE_ADDR + ADDR_W'(idx + IDX_ONE);
                    wr_data_nx = FILL_CHAR;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STATE_RST;
            idx      <= '0;
            prime    <= PRIME_RST;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            prime    <= prime_nx;
            wr_en    <= wr_en_nx;
            wr_addr  <= wr_addr_nx;
            wr_data  <= wr_data_nx;
            clr_done <= clr_done_nx;
        end
    end

endmodule

// File: tb/tb_char_buf_writer.sv
// Scoreboard bench for char_buf_writer: a cursor/cell model predicts writes, cursor, busy and clr_done.
module tb_char_buf_writer;

    localparam int                COLS      = 16;
    localparam int                ROWS      = 2;
    localparam int                ADDR_W    = 11;
    localparam int                CELLS     = ROWS * COLS;
    localparam logic [ADDR_W-1:0] BASE_ADDR = '0;
    localparam logic [7:0]        FILL_CHAR = 8'h20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [0:0]        cursor_row;
    logic [3:0]        cursor_col;
    logic              busy;
    logic              clr_done;

    char_buf_writer #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .FILL_CHAR (FILL_CHAR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .clr_done   (clr_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int at; } wr_t;
    typedef struct { int row;  int col;  int at; } cur_t;

    wr_t  wq[$];
    cur_t cq[$];
    int   dq[$];
    int   clr_lo = -1;
    int   clr_hi = -2;
    int   m_row = 0;
    int   m_col = 0;
    int   vectors = 0;
    int   checks = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: a screen of ROWS x COLS cells with a cursor.
    task automatic model_clear(input int k);
        for (int i = 0; i < CELLS; i++)
            wq.push_back('{addr: int'(BASE_ADDR) + i, data: int'(FILL_CHAR), at: k + 1 + i});
        clr_lo = k + 1;
        clr_hi = k + CELLS;
        dq.push_back(k + CELLS + 1);
        m_row = 0;
        m_col = 0;
        cq.push_back('{row: 0, col: 0, at: k + CELLS + 1});
    endtask

    task automatic model_byte(input logic [7:0] b, input int k);
        if (b >= 8'h20) begin
            wq.push_back('{addr: int'(BASE_ADDR) + m_row * COLS + m_col, data: int'(b), at: k + 1});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                wq.push_back('{addr: int'(BASE_ADDR) + m_row * COLS + m_col, data: int'(FILL_CHAR), at: k + 1});
            end
        end else if (b == 8'h0C) begin
            model_clear(k);
            return;
        end
        cq.push_back('{row: m_row, col: m_col, at: k + 1});
    endtask

    int   exp_wr, exp_d, exp_b;
    wr_t  mw;
    cur_t mc;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_wr = (wq.size() > 0 && wq[0].at <= cyc) ? 1 : 0;
            check("wr_en", int'(wr_en), exp_wr);
            if (exp_wr == 1) begin
                mw = wq.pop_front();
                if (wr_en) begin
                    check("wr_addr", int'(wr_addr), mw.addr);
                    check("wr_data", int'(wr_data), mw.data);
                    check("wr_cycle", cyc, mw.at);
                end
            end
            while (cq.size() > 0 && cq[0].at <= cyc) begin
                mc = cq.pop_front();
                check("cursor_row", int'(cursor_row), mc.row);
                check("cursor_col", int'(cursor_col), mc.col);
            end
            exp_d = (dq.size() > 0 && dq[0] <= cyc) ? 1 : 0;
            check("clr_done", int'(clr_done), exp_d);
            if (exp_d == 1) void'(dq.pop_front());
            exp_b = (cyc >= clr_lo && cyc <= clr_hi) ? 1 : 0;
            check("busy", int'(busy), exp_b);
            check("s_ready", int'(s_ready), 1 - exp_b);
        end else begin
            check("rst_wr_en", int'(wr_en), 0);
            check("rst_clr_done", int'(clr_done), 0);
        end
    end

    task automatic do_reset(input int hold);
        #2 rst_n = 1'b0;
        s_valid = 1'b0;
        wq.delete();
        cq.delete();
        dq.delete();
        clr_lo = -1;
        clr_hi = -2;
        m_row = 0;
        m_col = 0;
        #1;
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_cursor_row", int'(cursor_row), 0);
        check("rst_cursor_col", int'(cursor_col), 0);
        check("rst_wr_en_now", int'(wr_en), 0);
`ifdef CHARBUF_CLR_ON_RST_EN
        check("rst_busy", int'(busy), 1);
        check("rst_s_ready", int'(s_ready), 0);
`else
        check("rst_busy", int'(busy), 0);
        check("rst_s_ready", int'(s_ready), 1);
`endif
        repeat (hold) @(negedge clk);
        #2 rst_n = 1'b1;
`ifdef CHARBUF_CLR_ON_RST_EN
        model_clear(cyc);
`endif
    endtask

    task automatic send(input logic [7:0] b);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        guard   = 0;
        while (!s_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                $display("FAIL send_timeout: s_ready low for %0d cycles, required high", guard);
                $fatal(1, "send timeout");
            end
        end
        model_byte(b, cyc);
        vectors++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_data  = 8'($urandom);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((wq.size() > 0 || cq.size() > 0 || dq.size() > 0) && g < 200) begin
            idle(1);
            g++;
        end
        check("drain_writes", wq.size(), 0);
        check("drain_cursor", cq.size(), 0);
        check("drain_clr_done", dq.size(), 0);
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        int         kff;

        do_reset(3);

        send("A");
        send("B");
        idle(2);
        send(8'h0C);
        for (int i = 0; i < 17; i++) send(8'(8'h61 + i));
        send(8'h0D);
        for (int i = 0; i < 15; i++) send(8'(8'h41 + i));
        send("Z");
        for (int i = 0; i < 5; i++) send("x");
        send(8'h08);
        send(8'h0D);
        send(8'h08);
        idle(1);
        send(8'h0C);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                b = 8'($urandom_range(32, 255));
            end else if (r < 63) begin
                b = 8'h0D;
            end else if (r < 71) begin
                b = 8'h0A;
            end else if (r < 85) begin
                b = 8'h08;
            end else if (r < 95) begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
            end else begin
                b = 8'h0C;
            end
            send(b);
            r = int'($urandom_range(0, 3));
            if (r < 2) idle(r);
        end
        drain();

        // Abort a clear with reset while its 10th write is on the port.
        send(8'h0C);
        kff = cyc;
        while (cyc < kff + 10) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        do_reset(3);
        drain();
        send("Q");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
